// File: rtl/ualink_dpmem_pkg.sv
// Shared types and defaults for the dual-port RAM port-A arbiter.
// The statistics counters are enabled by defining UALINK_ARB_STATS_EN.
package ualink_dpmem_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 64;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic ID_R0 = 1'b0;
  localparam logic ID_R1 = 1'b1;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/ualink_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester not granted last wins.
module ualink_rr_arb2
  import ualink_dpmem_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic lastGnt_q;
  logic lastGnt_d;

  always_comb begin
    gnt0_o    = 1'b0;
    gnt1_o    = 1'b0;
    lastGnt_d = lastGnt_q;
    if (en_i) begin
      if (req0_i && (!req1_i || lastGnt_q == ID_R1)) begin
        gnt0_o = 1'b1;
      end else if (req1_i) begin
        gnt1_o = 1'b1;
      end
    end
    if (gnt0_o) begin
      lastGnt_d = ID_R0;
    end else if (gnt1_o) begin
      lastGnt_d = ID_R1;
    end
  end

  // Starting from r1 means r0 wins the first tie after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lastGnt_q <= ID_R1;
    end else begin
      lastGnt_q <= lastGnt_d;
    end
  end

endmodule

// File: rtl/ualink_dpmem_arb.sv
// Shares RAM port A between r0 and r1 after clearing every word once.
// Optional grant/conflict counters are enabled by UALINK_ARB_STATS_EN.
module ualink_dpmem_arb
  import ualink_dpmem_pkg::*;
#(
  parameter int                        ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                        DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                        DEPTH      = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_resetn,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  init_done
`ifdef UALINK_ARB_STATS_EN
  ,
  output logic [15:0]           r0_gnt_cnt,
  output logic [15:0]           r1_gnt_cnt,
  output logic [15:0]           conflict_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   initCnt_q, initCnt_d;
  logic                    initDone_q, initDone_d;
  logic                    rspPend_q, rspPend_d;
  logic                    rspId_q, rspId_d;
  logic [ADDR_WIDTH-1:0]   addrHold_q;
  logic                    memResetn_q;
  logic                    arbEn;
  logic                    gnt0;
  logic                    gnt1;

  assign arbEn = (state_q == ST_RUN);

  ualink_rr_arb2 u_arb (
    .clk_i  (axi_aclk),
    .rst_i  (axi_reset),
    .en_i   (arbEn),
    .req0_i (r0_valid),
    .req1_i (r1_valid),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  always_comb begin
    state_d    = state_q;
    initCnt_d  = initCnt_q;
    initDone_d = initDone_q;
    rspPend_d  = 1'b0;
    rspId_d    = rspId_q;
    mem_we     = 1'b0;
    mem_addr   = addrHold_q;
    mem_din    = INIT_VALUE;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = initCnt_q;
        initCnt_d = initCnt_q + 1'b1;
        if (initCnt_q == LAST_ADDR) begin
          state_d    = ST_RUN;
          initDone_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Only reads expect a response; the RAM's write-cycle dout is ignored.
        if (gnt0) begin
          mem_we    = r0_we;
          mem_addr  = r0_addr;
          mem_din   = r0_wdata;
          rspPend_d = !r0_we;
          rspId_d   = ID_R0;
        end else if (gnt1) begin
          mem_we    = r1_we;
          mem_addr  = r1_addr;
          mem_din   = r1_wdata;
          rspPend_d = !r1_we;
          rspId_d   = ID_R1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q     <= ST_INIT;
      initCnt_q   <= '0;
      initDone_q  <= 1'b0;
      rspPend_q   <= 1'b0;
      rspId_q     <= ID_R0;
      addrHold_q  <= '0;
      memResetn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      initCnt_q   <= initCnt_d;
      initDone_q  <= initDone_d;
      rspPend_q   <= rspPend_d;
      rspId_q     <= rspId_d;
      addrHold_q  <= mem_addr;
      memResetn_q <= 1'b1;
    end
  end

  assign r0_ready   = gnt0;
  assign r1_ready   = gnt1;
  assign r0_rvalid  = rspPend_q && (rspId_q == ID_R0);
  assign r1_rvalid  = rspPend_q && (rspId_q == ID_R1);
  assign r0_rdata   = mem_dout;
  assign r1_rdata   = mem_dout;
  assign init_done  = initDone_q;
  assign mem_resetn = memResetn_q;

`ifdef UALINK_ARB_STATS_EN
  logic [15:0] r0GntCnt_q;
  logic [15:0] r1GntCnt_q;
  logic [15:0] conflictCnt_q;

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r0GntCnt_q    <= '0;
      r1GntCnt_q    <= '0;
      conflictCnt_q <= '0;
    end else begin
      if (gnt0) begin
        r0GntCnt_q <= satInc(r0GntCnt_q);
      end
      if (gnt1) begin
        r1GntCnt_q <= satInc(r1GntCnt_q);
      end
      if (arbEn && r0_valid && r1_valid) begin
        conflictCnt_q <= satInc(conflictCnt_q);
      end
    end
  end

  assign r0_gnt_cnt   = r0GntCnt_q;
  assign r1_gnt_cnt   = r1GntCnt_q;
  assign conflict_cnt = conflictCnt_q;
`endif

endmodule

// File: tb/tb_ualink_dpmem_arb.sv
// Directed bench for ualink_dpmem_arb with a behavioural 1-cycle-latency RAM.
// Define UALINK_ARB_STATS_EN to also exercise the statistics counters.
module tb_ualink_dpmem_arb;

  logic        axi_aclk;
  logic        axi_reset;
  logic        r0_valid, r0_ready, r0_we, r0_rvalid;
  logic [7:0]  r0_addr;
  logic [63:0] r0_wdata, r0_rdata;
  logic        r1_valid, r1_ready, r1_we, r1_rvalid;
  logic [7:0]  r1_addr;
  logic [63:0] r1_wdata, r1_rdata;
  logic        mem_resetn, mem_we, init_done;
  logic [7:0]  mem_addr;
  logic [63:0] mem_din, mem_dout;
`ifdef UALINK_ARB_STATS_EN
  logic [15:0] r0_gnt_cnt, r1_gnt_cnt, conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] ram [256];

  ualink_dpmem_arb dut (
    .axi_aclk   (axi_aclk),
    .axi_reset  (axi_reset),
    .r0_valid   (r0_valid),
    .r0_ready   (r0_ready),
    .r0_we      (r0_we),
    .r0_addr    (r0_addr),
    .r0_wdata   (r0_wdata),
    .r0_rvalid  (r0_rvalid),
    .r0_rdata   (r0_rdata),
    .r1_valid   (r1_valid),
    .r1_ready   (r1_ready),
    .r1_we      (r1_we),
    .r1_addr    (r1_addr),
    .r1_wdata   (r1_wdata),
    .r1_rvalid  (r1_rvalid),
    .r1_rdata   (r1_rdata),
    .mem_resetn (mem_resetn),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .init_done  (init_done)
`ifdef UALINK_ARB_STATS_EN
    ,
    .r0_gnt_cnt   (r0_gnt_cnt),
    .r1_gnt_cnt   (r1_gnt_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  // RAM stand-in: registered read, and a marker value on dout during writes.
  always @(posedge axi_aclk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_din;
      mem_dout      <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else begin
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic we0, input logic [7:0] a0,
                               input logic [63:0] d0, input logic v1, input logic we1,
                               input logic [7:0] a1, input logic [63:0] d1);
    r0_valid = v0;
    r0_we    = we0;
    r0_addr  = a0;
    r0_wdata = d0;
    r1_valid = v1;
    r1_we    = we1;
    r1_addr  = a1;
    r1_wdata = d1;
    #1;
  endtask

  task automatic cycle();
    @(posedge axi_aclk);
    #1;
  endtask

  initial begin
    axi_reset = 1'b1;
    applyStimulus(0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0);
    repeat (3) cycle();

    // Reset state.
    checkOutput("rstInitDone", init_done, 0);
    checkOutput("rstMemResetn", mem_resetn, 0);
    checkOutput("rstRvalid", {r0_rvalid, r1_rvalid}, 0);
    checkOutput("rstReady", {r0_ready, r1_ready}, 0);

    // Full clear sweep after release: addresses 0..255 with INIT_VALUE.
    axi_reset = 1'b0;
    #1;
    checkOutput("memResetnHeld", mem_resetn, 0);
    for (int k = 0; k < 256; k++) begin
      checkOutput("sweepWeAddr", {mem_we, mem_addr}, {1'b1, 8'(k)});
      checkOutput("sweepDin", mem_din, 64'h0);
      checkOutput("sweepInitDone", init_done, 0);
      if (k == 1) checkOutput("memResetnUp", mem_resetn, 1);
      cycle();
    end
    checkOutput("initDoneRise", init_done, 1);
    checkOutput("runNoWe", mem_we, 0);

    // Read of a cleared word.
    applyStimulus(1, 0, 8'h05, 64'h0, 0, 0, 8'h00, 64'h0);
    checkOutput("rd5Ready", r0_ready, 1);
    cycle();
    applyStimulus(0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0);
    checkOutput("rd5Rvalid", {r0_rvalid, r1_rvalid}, 2'b10);
    checkOutput("rd5Data", r0_rdata, 64'h0);
    cycle();
    checkOutput("rd5Pulse", r0_rvalid, 0);

    // r0 writes 0x10, then r1 reads it back.
    applyStimulus(1, 1, 8'h10, 64'h1122334455667788, 0, 0, 8'h00, 64'h0);
    checkOutput("wrReady", r0_ready, 1);
    checkOutput("wrMem", {mem_we, mem_addr}, {1'b1, 8'h10});
    checkOutput("wrDin", mem_din, 64'h1122334455667788);
    cycle();
    applyStimulus(0, 0, 8'h00, 64'h0, 1, 0, 8'h10, 64'h0);
    checkOutput("rawReady", {r0_ready, r1_ready}, 2'b01);
    checkOutput("wrNoRvalid", {r0_rvalid, r1_rvalid}, 0);
    cycle();
    applyStimulus(0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0);
    checkOutput("rawRvalid", {r0_rvalid, r1_rvalid}, 2'b01);
    checkOutput("rawData", r1_rdata, 64'h1122334455667788);
    checkOutput("idleHoldAddr", {mem_we, mem_addr}, {1'b0, 8'h10});
    cycle();
    checkOutput("rawPulse", r1_rvalid, 0);

    // Six-cycle tie: last grant was r1, so r0,r1,r0,r1,r0,r1.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 8'(8'h20 + i), 64'(i), 1, 1, 8'(8'h30 + i), 64'(i));
      checkOutput("tieGrant", {r0_ready, r1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      cycle();
    end
`ifdef UALINK_ARB_STATS_EN
    // Cumulative since reset: r0 also had read 0x05 and write 0x10, r1 the read of 0x10.
    checkOutput("statR0", r0_gnt_cnt, 16'd5);
    checkOutput("statR1", r1_gnt_cnt, 16'd4);
    checkOutput("statConflict", conflict_cnt, 16'd6);
`endif
    applyStimulus(1, 1, 8'h40, 64'h0, 0, 0, 8'h00, 64'h0);
    checkOutput("soloR0", {r0_ready, r1_ready}, 2'b10);
    cycle();
    applyStimulus(1, 1, 8'h41, 64'h0, 1, 1, 8'h42, 64'h0);
    checkOutput("laterTie", {r0_ready, r1_ready}, 2'b01);
    cycle();

    // Fill 0x00..0x07 with distinct data, then r1 streams reads.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 8'(i), 64'hA000 + 64'(i), 0, 0, 8'h00, 64'h0);
      cycle();
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 8'h00, 64'h0, 1, 0, 8'(i), 64'h0);
      checkOutput("streamReady", r1_ready, 1);
      checkOutput("streamRvalid", r1_rvalid, (i > 0) ? 1 : 0);
      if (i > 0) checkOutput("streamData", r1_rdata, 64'hA000 + 64'(i - 1));
      cycle();
    end
    applyStimulus(0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0);
    checkOutput("streamLastRvalid", {r0_rvalid, r1_rvalid}, 2'b01);
    checkOutput("streamLastData", r1_rdata, 64'hA007);
    cycle();
    checkOutput("streamEnd", r1_rvalid, 0);

    // Reset, then reset again at sweep count 100.
    axi_reset = 1'b1;
    #1;
    checkOutput("rst2InitDone", init_done, 0);
    checkOutput("rst2MemResetn", mem_resetn, 0);
    cycle();
    axi_reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      checkOutput("partSweepAddr", mem_addr, 8'(k));
      cycle();
    end
    checkOutput("partAt100", {mem_we, mem_addr}, {1'b1, 8'd100});
    axi_reset = 1'b1;
    #1;
    checkOutput("midRstAddr", mem_addr, 8'h00);
    checkOutput("midRstResetn", mem_resetn, 0);
    cycle();

    // Held-off request during INIT, released on the first RUN cycle.
    axi_reset = 1'b0;
    applyStimulus(1, 0, 8'h03, 64'h0, 0, 0, 8'h00, 64'h0);
    for (int k = 0; k < 256; k++) begin
      checkOutput("resweepAddr", {mem_we, mem_addr}, {1'b1, 8'(k)});
      checkOutput("initHoldOff", r0_ready, 0);
      cycle();
    end
    checkOutput("reInitDone", init_done, 1);
    checkOutput("firstRunGrant", r0_ready, 1);
    checkOutput("firstRunMem", {mem_we, mem_addr}, {1'b0, 8'h03});
    cycle();
    applyStimulus(0, 0, 8'h00, 64'h0, 1, 0, 8'h03, 64'h0);
    checkOutput("clearedRvalid", {r0_rvalid, r1_rvalid}, 2'b10);
    checkOutput("clearedData", r0_rdata, 64'h0);
    checkOutput("r1GrantBeforeRst", r1_ready, 1);
    cycle();

    // Reset right after a read grant drops its response.
    axi_reset = 1'b1;
    applyStimulus(0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0);
    checkOutput("dropRvalid", {r0_rvalid, r1_rvalid}, 0);
    cycle();
    checkOutput("dropRvalidLater", {r0_rvalid, r1_rvalid}, 0);
    axi_reset = 1'b0;
    for (int k = 0; k < 256; k++) begin
      checkOutput("noRvalidInInit", {r0_rvalid, r1_rvalid}, 0);
      cycle();
    end
    checkOutput("finalInitDone", init_done, 1);

`ifdef UALINK_ARB_STATS_EN
    checkOutput("statRstR0", r0_gnt_cnt, 16'd0);
    applyStimulus(1, 1, 8'h50, 64'h0, 0, 0, 8'h00, 64'h0);
    repeat (65540) cycle();
    applyStimulus(0, 0, 8'h00, 64'h0, 0, 0, 8'h00, 64'h0);
    checkOutput("statSatR0", r0_gnt_cnt, 16'hFFFF);
    checkOutput("statSatR1", r1_gnt_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
